sep_gauss_conv_9x9: RTL

- Consumes the 9-row column stream from the 9-line rolling buffer: nine 21-bit signed pixels per cycle, plus hcount, vcount and valid.
- Applies a separable 9x9 binomial blur: a vertical 9-tap pass, then a horizontal 9-tap pass over a 9-column shift register.
- Emits one blurred 21-bit pixel per full window, aligned to the window-centre coordinates.
- Feeds the scale-space / difference stages downstream.

---
 rtl/sep_gauss_conv_9x9_if.sv | 66 ++++++
 rtl/sep_gauss_conv_9x9.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sep_gauss_conv_9x9_if.sv
// ---------------------------------------------------------------------------
// sep_gauss_conv_9x9_if
//
// Purpose: carries the column stream into the separable 9x9 Gaussian blur and
// the blurred pixel stream out of it.
//
// Signals:
//   line_buffer_in  [8:0][DATA_W-1:0] signed  nine rows of one column
//                                             (8 = oldest, 0 = newest, 4 = centre)
//   hcount_in       [COORD_W-1:0]             column of the incoming data
//   vcount_in       [COORD_W-1:0]             centre-row vcount
//   data_valid_in                             input column valid
//   pixel_out       [DATA_W-1:0] signed       blurred pixel
//   hcount_out      [COORD_W-1:0]             window-centre column
//   vcount_out      [COORD_W-1:0]             vcount of the newest column
//   data_valid_out                            one-cycle pulse per window
//   dog_out         [DATA_W:0] signed         centre pixel minus blurred pixel
//                                             (only with SEP_GAUSS_DOG_OUT_EN)
//
// Modports: master = stream source / result sink, slave = the blur block.
// ---------------------------------------------------------------------------
interface sep_gauss_conv_9x9_if #(
    parameter int DATA_W  = 21,
    parameter int COORD_W = 5
);
    logic signed [8:0][DATA_W-1:0] line_buffer_in;
    logic        [COORD_W-1:0]     hcount_in;
    logic        [COORD_W-1:0]     vcount_in;
    logic                          data_valid_in;

    logic signed [DATA_W-1:0]      pixel_out;
    logic        [COORD_W-1:0]     hcount_out;
    logic        [COORD_W-1:0]     vcount_out;
    logic                          data_valid_out;
`ifdef SEP_GAUSS_DOG_OUT_EN
    logic signed [DATA_W:0]        dog_out;
`endif

    modport master (
        output line_buffer_in,
        output hcount_in,
        output vcount_in,
        output data_valid_in,
        input  pixel_out,
        input  hcount_out,
        input  vcount_out,
`ifdef SEP_GAUSS_DOG_OUT_EN
        input  dog_out,
`endif
        input  data_valid_out
    );

    modport slave (
        input  line_buffer_in,
        input  hcount_in,
        input  vcount_in,
        input  data_valid_in,
        output pixel_out,
        output hcount_out,
        output vcount_out,
`ifdef SEP_GAUSS_DOG_OUT_EN
        output dog_out,
`endif
        output data_valid_out
    );
endinterface

// File: rtl/sep_gauss_conv_9x9.sv
// ---------------------------------------------------------------------------
// sep_gauss_conv_9x9
//
// Purpose: separable 9x9 binomial blur (taps 1,8,28,56,70,56,28,8,1, sum 256)
// over the 9-row column stream of the rolling line buffer. A vertical 9-tap
// pass collapses each incoming column to one value; a horizontal 9-tap pass
// over the last nine such values produces one blurred pixel per full window,
// tagged with the window-centre coordinates. Both passes round to nearest
// (add half, arithmetic shift by 8).
//
// Pipeline (4 register stages, input column to data_valid_out):
//   s1  vertical sum v, coordinates, valid
//   s2  vn = round(v/256) shifted into the 9-entry column register, col_cnt
//   s3  horizontal sum h, win_ok, centre coordinates
//   s4  pixel_out = round(h/256), coordinates, data_valid_out
//
// Ports:
//   clk_in   system clock
//   rst_in   asynchronous, active-low reset; clears every register
//   io       sep_gauss_conv_9x9_if.slave (column stream in, pixel stream out)
//
// Parameters: DATA_W pixel width (signed), ACC_W accumulator width
// (needs ACC_W >= DATA_W+9), COORD_W coordinate width.
//
// Build option: define SEP_GAUSS_DOG_OUT_EN to add io.dog_out, the centre
// original pixel minus the blurred pixel, with the same timing and valid.
// ---------------------------------------------------------------------------
module sep_gauss_conv_9x9 #(
    parameter int DATA_W  = 21,
    parameter int ACC_W   = 30,
    parameter int COORD_W = 5
) (
    input  logic                clk_in,
    input  logic                rst_in,
    sep_gauss_conv_9x9_if.slave io
);

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(128);
    localparam logic        [3:0]       WIN_LEN  = 4'd9;

    function automatic logic signed [ACC_W-1:0] tap(input int i);
        logic signed [ACC_W-1:0] t;
        case (i)
            0, 8:    t = ACC_W'(1);
            1, 7:    t = ACC_W'(8);
            2, 6:    t = ACC_W'(28);
            3, 5:    t = ACC_W'(56);
            4:       t = ACC_W'(70);
            default: t = '0;
        endcase
        return t;
    endfunction

    function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_W-1:0] x);
        return {{(ACC_W-DATA_W){x[DATA_W-1]}}, x};
    endfunction

    // ---------------- stage 1: vertical pass ----------------
    logic signed [ACC_W-1:0]   v_sum;
    logic signed [ACC_W-1:0]   s1_v;
    logic        [COORD_W-1:0] s1_hc;
    logic        [COORD_W-1:0] s1_vc;
    logic                      s1_valid;

    always_comb begin
        v_sum = '0;
        for (int i = 0; i < 9; i++) begin
            v_sum = v_sum + sext(io.line_buffer_in[i]) * tap(i);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1_v     <= '0;
            s1_hc    <= '0;
            s1_vc    <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_v     <= v_sum;
            s1_hc    <= io.hcount_in;
            s1_vc    <= io.vcount_in;
            s1_valid <= io.data_valid_in;
        end
    end

    // ---------------- stage 2: normalise + column shift ----------------
    // |v| <= 256 * 2^(DATA_W-1), so the rounded quotient always fits DATA_W;
    // taking bits [DATA_W+7:8] is the arithmetic shift followed by truncation.
    logic signed [ACC_W-1:0]       v_rnd;
    logic signed [DATA_W-1:0]      vn;
    logic        [8:0][DATA_W-1:0] col;
    logic        [3:0]             col_cnt;
    logic        [COORD_W-1:0]     s2_hc;
    logic        [COORD_W-1:0]     s2_vc;
    logic                          s2_valid;

    assign v_rnd = s1_v + RND_HALF;
    assign vn    = v_rnd[DATA_W+7:8];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            col      <= '0;
            col_cnt  <= '0;
            s2_hc    <= '0;
            s2_vc    <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_hc    <= s1_hc;
            s2_vc    <= s1_vc;
            s2_valid <= s1_valid;
            if (s1_valid) begin
                col <= {col[7:0], vn};
                // A column at hcount 0 starts a new row: any partial window
                // left over from the previous row is forgotten by the count.
                if (s1_hc == '0) begin
                    col_cnt <= 4'd1;
                end else if (col_cnt != WIN_LEN) begin
                    col_cnt <= col_cnt + 4'd1;
                end
            end
        end
    end

    // ---------------- stage 3: horizontal pass ----------------
    logic signed [ACC_W-1:0]   h_sum;
    logic signed [ACC_W-1:0]   s3_h;
    logic        [COORD_W-1:0] s3_hc;
    logic        [COORD_W-1:0] s3_vc;
    logic                      s3_ok;

    always_comb begin
        h_sum = '0;
        for (int j = 0; j < 9; j++) begin
            h_sum = h_sum + sext(col[j]) * tap(j);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s3_h  <= '0;
            s3_hc <= '0;
            s3_vc <= '0;
            s3_ok <= 1'b0;
        end else begin
            s3_h  <= h_sum;
            // Newest column sits at col[0]; the window centre is four back.
            s3_hc <= s2_hc - COORD_W'(4);
            s3_vc <= s2_vc;
            s3_ok <= s2_valid && (col_cnt == WIN_LEN);
        end
    end

    // ---------------- stage 4: normalise + output ----------------
    logic signed [ACC_W-1:0]  h_rnd;
    logic signed [DATA_W-1:0] pix_nxt;

    assign h_rnd   = s3_h + RND_HALF;
    assign pix_nxt = h_rnd[DATA_W+7:8];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            io.pixel_out      <= '0;
            io.hcount_out     <= '0;
            io.vcount_out     <= '0;
            io.data_valid_out <= 1'b0;
        end else begin
            io.data_valid_out <= s3_ok;
            if (s3_ok) begin
                io.pixel_out  <= pix_nxt;
                io.hcount_out <= s3_hc;
                io.vcount_out <= s3_vc;
            end
        end
    end

`ifdef SEP_GAUSS_DOG_OUT_EN
    // Centre-row originals travel in a shift register parallel to col so the
    // entry at ctr[4] is always the original of the column blurred at col[4].
    logic        [DATA_W-1:0]      s1_ctr;
    logic        [8:0][DATA_W-1:0] ctr;
    logic        [DATA_W-1:0]      s3_ctr;
    logic signed [DATA_W:0]        dog_nxt;

    assign dog_nxt = $signed({s3_ctr[DATA_W-1], s3_ctr})
                   - $signed({pix_nxt[DATA_W-1], pix_nxt});

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1_ctr     <= '0;
            ctr        <= '0;
            s3_ctr     <= '0;
            io.dog_out <= '0;
        end else begin
            s1_ctr <= io.line_buffer_in[4];
            if (s1_valid) begin
                ctr <= {ctr[7:0], s1_ctr};
            end
            s3_ctr <= ctr[4];
            if (s3_ok) begin
                io.dog_out <= dog_nxt;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{v_rnd[7:0], v_rnd[ACC_W-1:DATA_W+8],
                           h_rnd[7:0], h_rnd[ACC_W-1:DATA_W+8], ctr[8]};
`else
    logic unused_bits;
    assign unused_bits = ^{v_rnd[7:0], v_rnd[ACC_W-1:DATA_W+8],
                           h_rnd[7:0], h_rnd[ACC_W-1:DATA_W+8]};
`endif

endmodule
